// File: rtl/ami_w_arb.sv
// Round-robin AXI write master: merges NCH user AW/W/B ports onto one AXI write channel.
// Latency: AW 1 cycle (registered slot); W and B are combinational through the head/ID mux.
// Backpressure: AW grant stalls on a held AW slot, the outstanding limit or a full order queue; W and B pass ready through.
module ami_w_arb #(
    parameter int NCH    = 4,
    parameter int AXI_DW = 128,
    parameter int AXI_AW = 32,
    parameter int AXI_IW = 8,
    parameter int AXI_LW = 8,
    parameter int AXI_SW = 3,
    parameter int AMI_OD = 4,
    parameter int AMI_OQ = 4,
    localparam int CHW        = $clog2(NCH),
    localparam int AXI_WSTRBW = AXI_DW / 8
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    output logic [AXI_IW-1:0]          AWID,
    output logic [AXI_AW-1:0]          AWADDR,
    output logic [AXI_LW-1:0]          AWLEN,
    output logic [AXI_SW-1:0]          AWSIZE,
    output logic [1:0]                 AWBURST,
    output logic                       AWVALID,
    input  logic                       AWREADY,
    output logic [AXI_DW-1:0]          WDATA,
    output logic [AXI_WSTRBW-1:0]      WSTRB,
    output logic                       WLAST,
    output logic                       WVALID,
    input  logic                       WREADY,
    input  logic [AXI_IW-1:0]          BID,
    input  logic [1:0]                 BRESP,
    input  logic                       BVALID,
    output logic                       BREADY,
    input  logic [NCH*AXI_IW-1:0]      usr_awid,
    input  logic [NCH*AXI_AW-1:0]      usr_awaddr,
    input  logic [NCH*AXI_LW-1:0]      usr_awlen,
    input  logic [NCH*AXI_SW-1:0]      usr_awsize,
    input  logic [NCH*2-1:0]           usr_awburst,
    input  logic [NCH-1:0]             usr_awvalid,
    output logic [NCH-1:0]             usr_awready,
    input  logic [NCH*AXI_DW-1:0]      usr_wdata,
    input  logic [NCH*AXI_WSTRBW-1:0]  usr_wstrb,
    input  logic [NCH-1:0]             usr_wlast,
    input  logic [NCH-1:0]             usr_wvalid,
    output logic [NCH-1:0]             usr_wready,
    output logic [AXI_IW-1:0]          usr_bid,
    output logic [1:0]                 usr_bresp,
    output logic [NCH-1:0]             usr_bvalid,
    input  logic [NCH-1:0]             usr_bready,
    output logic [NCH-1:0]             wlast_err
);

    localparam int OQW = $clog2(AMI_OQ);
    localparam int OCW = $clog2(AMI_OD + 1);

    logic                aw_vld_q, aw_vld_d;
    logic [AXI_IW-1:0]   awid_q, awid_d;
    logic [AXI_AW-1:0]   awaddr_q, awaddr_d;
    logic [AXI_LW-1:0]   awlen_q, awlen_d;
    logic [AXI_SW-1:0]   awsize_q, awsize_d;
    logic [1:0]          awburst_q, awburst_d;
    logic [CHW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [OCW-1:0]      ost_cc_q, ost_cc_d;
    logic [CHW-1:0]      oq_port_q [AMI_OQ];
    logic [CHW-1:0]      oq_port_d [AMI_OQ];
    logic [AXI_LW-1:0]   oq_len_q [AMI_OQ];
    logic [AXI_LW-1:0]   oq_len_d [AMI_OQ];
    logic [OQW-1:0]      oq_wp_q, oq_wp_d, oq_rp_q, oq_rp_d;
    logic [OQW:0]        oq_cnt_q, oq_cnt_d;
    logic [AXI_LW-1:0]   beat_cc_q, beat_cc_d;

    logic                can_grant, gnt_vld;
    logic [CHW-1:0]      gnt_idx, cand;
    logic                oq_full, oq_empty, oq_push, oq_pop, w_hs, b_ok, b_hs;
    logic [CHW-1:0]      head_port, b_port;
    logic [AXI_LW-1:0]   head_len;
    logic [AXI_IW-1:0]   id_sel;

    assign oq_full   = (oq_cnt_q == (OQW+1)'(AMI_OQ));
    assign oq_empty  = (oq_cnt_q == '0);
    assign can_grant = ARESETn && (!aw_vld_q || AWREADY) && (ost_cc_q < OCW'(AMI_OD)) && !oq_full;

    // Pick the first requesting port at or after the round-robin pointer.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = CHW'((int'(rr_ptr_q) + i) % NCH);
            if (!gnt_vld && usr_awvalid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_vld = gnt_vld && can_grant;
    end

    // One-hot AW ready back to the granted port.
    always_comb begin
        usr_awready = '0;
        for (int c = 0; c < NCH; c++) begin
            usr_awready[c] = gnt_vld && (gnt_idx == CHW'(c));
        end
    end

    assign id_sel = usr_awid[gnt_idx*AXI_IW +: AXI_IW];

    // Load the AW slot on grant, clear it once the slave takes it; port index replaces ID low bits.
    always_comb begin
        aw_vld_d  = aw_vld_q;
        awid_d    = awid_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        awsize_d  = awsize_q;
        awburst_d = awburst_q;
        rr_ptr_d  = rr_ptr_q;
        if (gnt_vld) begin
            aw_vld_d            = 1'b1;
            awid_d              = id_sel;
            awid_d[CHW-1:0]     = gnt_idx;
            awaddr_d            = usr_awaddr[gnt_idx*AXI_AW +: AXI_AW];
            awlen_d             = usr_awlen[gnt_idx*AXI_LW +: AXI_LW];
            awsize_d            = usr_awsize[gnt_idx*AXI_SW +: AXI_SW];
            awburst_d           = usr_awburst[gnt_idx*2 +: 2];
            rr_ptr_d            = (gnt_idx == CHW'(NCH-1)) ? '0 : gnt_idx + 1'b1;
        end else if (AWREADY) begin
            aw_vld_d = 1'b0;
        end
    end

    assign AWVALID = aw_vld_q;
    assign AWID    = awid_q;
    assign AWADDR  = awaddr_q;
    assign AWLEN   = awlen_q;
    assign AWSIZE  = awsize_q;
    assign AWBURST = awburst_q;

    // W path steered by the order-queue head; WLAST comes from the burst length, not the user.
    assign head_port = oq_port_q[oq_rp_q];
    assign head_len  = oq_len_q[oq_rp_q];
    assign WVALID    = !oq_empty && usr_wvalid[head_port];
    assign WLAST     = !oq_empty && (beat_cc_q == head_len);
    assign WDATA     = usr_wdata[head_port*AXI_DW +: AXI_DW];
    assign WSTRB     = usr_wstrb[head_port*AXI_WSTRBW +: AXI_WSTRBW];
    assign w_hs      = WVALID && WREADY;
    assign oq_push   = gnt_vld;
    assign oq_pop    = w_hs && WLAST;

    // Per-port W ready and last-beat disagreement flag.
    always_comb begin
        usr_wready = '0;
        wlast_err  = '0;
        for (int c = 0; c < NCH; c++) begin
            usr_wready[c] = (head_port == CHW'(c)) && !oq_empty && WREADY;
            wlast_err[c]  = w_hs && (head_port == CHW'(c)) && (usr_wlast[c] != WLAST);
        end
    end

    // B routing by ID low bits; responses for a nonexistent port are swallowed.
    assign b_port  = BID[CHW-1:0];
    assign b_ok    = (int'(b_port) < NCH);
    assign BREADY  = b_ok ? usr_bready[b_port] : 1'b1;
    assign b_hs    = BVALID && BREADY;
    assign usr_bid   = BID;
    assign usr_bresp = BRESP;

    always_comb begin
        usr_bvalid = '0;
        for (int c = 0; c < NCH; c++) begin
            usr_bvalid[c] = BVALID && (b_port == CHW'(c));
        end
    end

    // Outstanding count, order-queue bookkeeping and beat counter.
    always_comb begin
        ost_cc_d = ost_cc_q;
        if (gnt_vld && !b_hs) begin
            ost_cc_d = ost_cc_q + 1'b1;
        end else if (b_hs && !gnt_vld && (ost_cc_q != '0)) begin
            ost_cc_d = ost_cc_q - 1'b1;
        end
        oq_port_d = oq_port_q;
        oq_len_d  = oq_len_q;
        oq_wp_d   = oq_wp_q;
        oq_rp_d   = oq_rp_q;
        oq_cnt_d  = oq_cnt_q;
        if (oq_push) begin
            oq_port_d[oq_wp_q] = gnt_idx;
            oq_len_d[oq_wp_q]  = usr_awlen[gnt_idx*AXI_LW +: AXI_LW];
            oq_wp_d            = oq_wp_q + 1'b1;
        end
        if (oq_pop) begin
            oq_rp_d = oq_rp_q + 1'b1;
        end
        if (oq_push && !oq_pop) begin
            oq_cnt_d = oq_cnt_q + 1'b1;
        end else if (oq_pop && !oq_push) begin
            oq_cnt_d = oq_cnt_q - 1'b1;
        end
        beat_cc_d = beat_cc_q;
        if (w_hs) begin
            beat_cc_d = WLAST ? '0 : beat_cc_q + 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            aw_vld_q  <= 1'b0;
            awid_q    <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            rr_ptr_q  <= '0;
            ost_cc_q  <= '0;
            oq_wp_q   <= '0;
            oq_rp_q   <= '0;
            oq_cnt_q  <= '0;
            beat_cc_q <= '0;
            for (int i = 0; i < AMI_OQ; i++) begin
                oq_port_q[i] <= '0;
                oq_len_q[i]  <= '0;
            end
        end else begin
            aw_vld_q  <= aw_vld_d;
            awid_q    <= awid_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            awsize_q  <= awsize_d;
            awburst_q <= awburst_d;
            rr_ptr_q  <= rr_ptr_d;
            ost_cc_q  <= ost_cc_d;
            oq_wp_q   <= oq_wp_d;
            oq_rp_q   <= oq_rp_d;
            oq_cnt_q  <= oq_cnt_d;
            beat_cc_q <= beat_cc_d;
            oq_port_q <= oq_port_d;
            oq_len_q  <= oq_len_d;
        end
    end

endmodule
